// File: rtl/io_output_disp_if.sv
// CPU data-memory bus as seen by the output I/O block.
//   addr   : CPU byte address (only addr[7:2] is decoded by the output block)
//   datain : CPU store data
//   wen    : store strobe, valid for the whole cycle
// master = CPU side (drives the bus), slave = output block (samples it).
interface io_output_disp_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        wen;

    modport master (output addr, output datain, output wen);
    modport slave  (input  addr, input  datain, input  wen);
endinterface

// File: rtl/io_output_disp.sv
// Memory-mapped output ports with a round-robin seven-segment display engine.
// Stores to the I/O window land in three 32-bit port registers. A shift-add-3
// engine converts the low byte of one port at a time (10 cycles per port) and
// drives that port's tens/units digits. The hundreds digit is dropped, so the
// display shows the value mod 100.
// Ports:
//   io_clk            : sole clock, rising edge
//   resetn            : synchronous reset, active-low
//   bus               : CPU store bus (addr, datain, wen), slave side
//   out_port0..2      : port registers
//   dt0/dt1 .. dt4/dt5: tens/units digits of port 0..2, active-low {g,f,e,d,c,b,a}
//   refresh           : one-cycle pulse when port 2's digits are written (round complete)
module io_output_disp #(
    parameter logic [5:0] SEL0 = 6'b100000,
    parameter logic [5:0] SEL1 = 6'b100001,
    parameter logic [5:0] SEL2 = 6'b100010
) (
    input  logic              io_clk,
    input  logic              resetn,
    io_output_disp_if.slave   bus,
    output logic [31:0]       out_port0,
    output logic [31:0]       out_port1,
    output logic [31:0]       out_port2,
    output logic [6:0]        dt0,
    output logic [6:0]        dt1,
    output logic [6:0]        dt2,
    output logic [6:0]        dt3,
    output logic [6:0]        dt4,
    output logic [6:0]        dt5,
    output logic              refresh
);

    typedef enum logic [1:0] {LOAD, SHIFT, STORE} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t      state, state_nxt;
    logic [1:0]  idx;
    logic [7:0]  shreg;
    logic [11:0] bcd;
    logic [11:0] bcd_adj;
    logic [2:0]  bit_cnt;
    logic [7:0]  port_byte;
    logic        load_en, shift_en, store_en;

    // Only addr[7:2] selects a port; the remaining address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // ---------------- write path ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what lets a LOAD in the same cycle
    // as a store to that port see the old port value.
    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            out_port0 <= '0;
            out_port1 <= '0;
            out_port2 <= '0;
        end else if (bus.wen) begin
            case (bus.addr[7:2])
                SEL0:    out_port0 <= bus.datain;
                SEL1:    out_port1 <= bus.datain;
                SEL2:    out_port2 <= bus.datain;
                default: ;
            endcase
        end
    end

    // ---------------- conversion FSM ----------------
    always_ff @(posedge io_clk) begin
        if (!resetn) state <= LOAD;
        else         state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == 3'd7) state_nxt = STORE;
            STORE:   state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        load_en  = (state == LOAD);
        shift_en = (state == SHIFT);
        store_en = (state == STORE);
        refresh  = store_en && (idx == 2'd2);
    end

    // ---------------- datapath ----------------
    always_comb begin
        port_byte = 8'h00;
        case (idx)
            2'd0:    port_byte = out_port0[7:0];
            2'd1:    port_byte = out_port1[7:0];
            2'd2:    port_byte = out_port2[7:0];
            default: port_byte = 8'h00;
        endcase
    end

    // Pre-shift correction: any BCD nibble >= 5 gets +3 so the shift carries
    // correctly into the next decade.
    always_comb begin
        bcd_adj = bcd;
        for (int n = 0; n < 3; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
        end
    end

    // NOTE: the digit registers are reset to blank because they drive the
    // board directly; the shift/BCD registers are reset too so a reset
    // mid-conversion cannot leak partial results into a later STORE.
    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            idx     <= 2'd0;
            shreg   <= 8'h00;
            bcd     <= 12'h000;
            bit_cnt <= 3'd0;
            dt0     <= SEG_BLANK;
            dt1     <= SEG_BLANK;
            dt2     <= SEG_BLANK;
            dt3     <= SEG_BLANK;
            dt4     <= SEG_BLANK;
            dt5     <= SEG_BLANK;
        end else begin
            if (load_en) begin
                shreg   <= port_byte;
                bcd     <= 12'h000;
                bit_cnt <= 3'd0;
            end
            if (shift_en) begin
                {bcd, shreg} <= {bcd_adj, shreg} << 1;
                bit_cnt      <= bit_cnt + 3'd1;
            end
            if (store_en) begin
                // bcd[11:8] (hundreds) is deliberately discarded.
                case (idx)
                    2'd0: begin dt0 <= seg7(bcd[7:4]); dt1 <= seg7(bcd[3:0]); end
                    2'd1: begin dt2 <= seg7(bcd[7:4]); dt3 <= seg7(bcd[3:0]); end
                    2'd2: begin dt4 <= seg7(bcd[7:4]); dt5 <= seg7(bcd[3:0]); end
                    default: ;
                endcase
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_io_output_disp.sv
// Self-checking bench for io_output_disp: table-driven write-path vectors plus
// directed sequences for reset timing, display contents, LOAD/store collision
// and mid-conversion reset.
module tb_io_output_disp;

    logic        io_clk;
    logic        resetn;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [6:0]  dt0, dt1, dt2, dt3, dt4, dt5;
    logic        refresh;

    io_output_disp_if bus ();

    io_output_disp dut (
        .io_clk    (io_clk),
        .resetn    (resetn),
        .bus       (bus),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2),
        .dt0       (dt0),
        .dt1       (dt1),
        .dt2       (dt2),
        .dt3       (dt3),
        .dt4       (dt4),
        .dt5       (dt5),
        .refresh   (refresh)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    int errors = 0;
    int checks = 0;

    // Reference segment patterns, index 10 = blank.
    logic [6:0] seg_ref [11];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wen;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } wvec_t;

    wvec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_digits(input string tag, input int d0, input int d1, input int d2,
                                input int d3, input int d4, input int d5);
        check({tag, "_dt0"}, {25'd0, dt0}, {25'd0, seg_ref[d0]});
        check({tag, "_dt1"}, {25'd0, dt1}, {25'd0, seg_ref[d1]});
        check({tag, "_dt2"}, {25'd0, dt2}, {25'd0, seg_ref[d2]});
        check({tag, "_dt3"}, {25'd0, dt3}, {25'd0, seg_ref[d3]});
        check({tag, "_dt4"}, {25'd0, dt4}, {25'd0, seg_ref[d4]});
        check({tag, "_dt5"}, {25'd0, dt5}, {25'd0, seg_ref[d5]});
    endtask

    // Called at a negedge; advances negedge by negedge until refresh is seen.
    task automatic wait_refresh(input string tag, input int limit, output int n);
        n = 0;
        while (!refresh && n < limit) begin
            @(negedge io_clk);
            n++;
        end
        if (!refresh) begin
            errors++;
            checks++;
            $display("FAIL %s: refresh timeout after %0d cycles, required within %0d", tag, n, limit);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge io_clk);
        bus.addr   = a;
        bus.datain = d;
        bus.wen    = 1'b1;
        @(negedge io_clk);
        bus.wen    = 1'b0;
    endtask

    task automatic wait_full_round(input string tag);
        int n;
        wait_refresh(tag, 40, n);
        @(negedge io_clk);
        wait_refresh(tag, 40, n);
        @(negedge io_clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t;

        seg_ref[0]  = 7'b1000000;
        seg_ref[1]  = 7'b1111001;
        seg_ref[2]  = 7'b0100100;
        seg_ref[3]  = 7'b0110000;
        seg_ref[4]  = 7'b0011001;
        seg_ref[5]  = 7'b0010010;
        seg_ref[6]  = 7'b0000010;
        seg_ref[7]  = 7'b1111000;
        seg_ref[8]  = 7'b0000000;
        seg_ref[9]  = 7'b0010000;
        seg_ref[10] = 7'b1111111;

        //            addr           data          wen   p0      p1     p2
        vecs[0] = '{32'h0000_0080, 32'd42,        1'b1, 32'd42, 32'd0, 32'd0};
        vecs[1] = '{32'h0000_0084, 32'd7,         1'b1, 32'd42, 32'd7, 32'd0};
        vecs[2] = '{32'h0000_0088, 32'd99,        1'b1, 32'd42, 32'd7, 32'd99};
        vecs[3] = '{32'h0000_008C, 32'hDEAD_BEEF, 1'b1, 32'd42, 32'd7, 32'd99};
        vecs[4] = '{32'h0000_0080, 32'h55,        1'b0, 32'd42, 32'd7, 32'd99};
        vecs[5] = '{32'hFFFF_FF83, 32'h11,        1'b1, 32'h11, 32'd7, 32'd99};
        vecs[6] = '{32'h0000_0080, 32'd42,        1'b1, 32'd42, 32'd7, 32'd99};

        bus.addr   = '0;
        bus.datain = '0;
        bus.wen    = 1'b0;
        resetn     = 1'b0;

        // ---- 1: reset, first round timing, initial digits ----
        repeat (3) @(posedge io_clk);
        @(negedge io_clk);
        check("rst_p0", out_port0, 32'd0);
        check("rst_p1", out_port1, 32'd0);
        check("rst_p2", out_port2, 32'd0);
        check("rst_refresh", {31'd0, refresh}, 32'd0);
        check_digits("rst", 10, 10, 10, 10, 10, 10);

        resetn = 1'b1;
        n = 0;
        while (!refresh && n < 100) begin
            @(negedge io_clk);
            n++;
            if (n == 9)  check("p0_store_cycle_dt0_blank", {25'd0, dt0}, {25'd0, seg_ref[10]});
            if (n == 10) check("p0_after_store_dt0", {25'd0, dt0}, {25'd0, seg_ref[0]});
            if (n == 10) check("p1_still_blank_dt2", {25'd0, dt2}, {25'd0, seg_ref[10]});
        end
        check("first_refresh_cycle", n + 1, 32'd30);
        @(negedge io_clk);
        check("refresh_one_cycle", {31'd0, refresh}, 32'd0);
        check_digits("round1", 0, 0, 0, 0, 0, 0);

        // ---- 4 (and the writes of 2): write path vectors ----
        for (int i = 0; i < 7; i++) begin
            @(negedge io_clk);
            bus.addr   = vecs[i].addr;
            bus.datain = vecs[i].data;
            bus.wen    = vecs[i].wen;
            @(negedge io_clk);
            bus.wen    = 1'b0;
            check($sformatf("vec%0d_p0", i), out_port0, vecs[i].e0);
            check($sformatf("vec%0d_p1", i), out_port1, vecs[i].e1);
            check($sformatf("vec%0d_p2", i), out_port2, vecs[i].e2);
        end

        // ---- 2: digits for 42 / 7 / 99 ----
        wait_full_round("t2");
        check_digits("t2", 4, 2, 0, 7, 9, 9);

        // ---- 3: 255 -> "55", 0x78 (120) -> "20" ----
        do_write(32'h80, 32'd255);
        do_write(32'h84, 32'h1234_5678);
        check("t3_p1_readback", out_port1, 32'h1234_5678);
        check("t3_p0_readback", out_port0, 32'd255);
        wait_full_round("t3");
        check_digits("t3", 5, 5, 2, 0, 9, 9);

        // ---- 5: store to port 0 during its LOAD cycle ----
        wait_refresh("t5_sync", 40, n);
        @(negedge io_clk);                 // now in LOAD for port 0 (t=0)
        bus.addr   = 32'h80;
        bus.datain = 32'd33;
        bus.wen    = 1'b1;
        @(negedge io_clk);                 // t=1
        bus.wen    = 1'b0;
        check("t5_p0_written", out_port0, 32'd33);
        t = 1;
        wait_refresh("t5_round", 40, n);
        t = t + n;
        @(negedge io_clk);
        t++;
        check("t5_old_dt0", {25'd0, dt0}, {25'd0, seg_ref[5]});
        check("t5_old_dt1", {25'd0, dt1}, {25'd0, seg_ref[5]});
        while (!(dt0 == seg_ref[3] && dt1 == seg_ref[3]) && t < 100) begin
            @(negedge io_clk);
            t++;
        end
        checks++;
        if (t > 40) begin
            errors++;
            $display("FAIL t5_latency: new digits after %0d cycles, required at most 40", t);
        end

        // ---- 6: reset during port 1 SHIFT ----
        wait_refresh("t6_sync", 40, n);
        @(negedge io_clk);                 // LOAD port 0, t=0
        repeat (13) @(negedge io_clk);     // t=13: SHIFT for port 1
        resetn = 1'b0;
        @(negedge io_clk);
        check("t6_p0", out_port0, 32'd0);
        check("t6_p1", out_port1, 32'd0);
        check("t6_p2", out_port2, 32'd0);
        check("t6_refresh", {31'd0, refresh}, 32'd0);
        check_digits("t6_rst", 10, 10, 10, 10, 10, 10);
        resetn = 1'b1;
        wait_refresh("t6_restart", 100, n);
        check("t6_first_refresh_cycle", n + 1, 32'd30);
        @(negedge io_clk);
        check_digits("t6_round", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_output_disp.md
Name: io_output_disp

Overview:
- Memory-mapped output side of the single-cycle CPU I/O subsystem; write-direction counterpart of the input port block.
- CPU store instructions addressed to the I/O window are captured into three 32-bit output port registers.
- A sequential binary-to-BCD engine (shift-add-3, one bit per cycle) round-robins the ports and drives two seven-segment digits per port: the low 8 bits of each port, shown mod 100.
- Sits between the CPU data-memory bus and the board's LEDs and seven-segment displays.

Parameters:
- SEL0, 6'b100000, addr[7:2] value selecting out_port0
- SEL1, 6'b100001, addr[7:2] value selecting out_port1
- SEL2, 6'b100010, addr[7:2] value selecting out_port2

Ports:
- io_clk  input  1  sole clock; all state updates on rising edge
- resetn  input  1  synchronous reset, active-low
- addr  input  32  CPU byte address; only addr[7:2] decoded
- datain  input  32  CPU store data
- wen  input  1  store strobe, valid for the whole cycle
- out_port0  output  32  port 0 register
- out_port1  output  32  port 1 register
- out_port2  output  32  port 2 register
- dt0, dt1  output  7  port 0 tens, units digit
- dt2, dt3  output  7  port 1 tens, units digit
- dt4, dt5  output  7  port 2 tens, units digit
- refresh  output  1  one-cycle pulse when a full 3-port display round completes

Behaviour:
- Reset: resetn=0 at a rising edge clears all state:
  - out_port0..2 = 0
  - dt0..dt5 = 7'b1111111 (blank)
  - refresh = 0
  - FSM = LOAD, port index = 0
  - Reset mid-conversion aborts the conversion; no partial digits are written.
- Write path:
  - At a rising edge with wen=1, a matching addr[7:2] loads datain into that port. Visible the next cycle.
  - addr[1:0] and addr[31:8] are ignored.
  - A non-matching address or wen=0 leaves all ports unchanged.
  - Only one port can be written per cycle.
- Segment encoding:
  - dt[6:0] = {g,f,e,d,c,b,a}, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Non-BCD codes never occur; the encoder must still map them to blank.
- Conversion FSM (states LOAD, SHIFT, STORE):
  - LOAD (1 cycle): snapshot out_port[idx][7:0] into an 8-bit shift register; clear the 12-bit BCD register {H,T,U}; bit counter = 0.
  - SHIFT (8 cycles): each cycle, first add 3 to any BCD nibble >= 5, then shift {BCD,shreg} left by 1; counter increments. Exit after the 8th shift.
  - STORE (1 cycle):
    - Write encoded T to the tens digit and U to the units digit of port idx; H is discarded, giving mod 100.
    - Other ports' digits hold.
    - idx advances 0->1->2->0.
    - refresh = 1 on the STORE cycle with idx=2.
    - Next state is LOAD.
- Timing:
  - 10 cycles per port; 30-cycle round.
  - The first refresh pulse comes on cycle 30 after reset release.
  - A write to port k is reflected on its digits within at most 40 cycles.
- Simultaneous events:
  - A write to the port currently in LOAD still gives LOAD the old value (register read before update).
  - The new value is shown in the next round.
  - Writes during SHIFT/STORE do not disturb the conversion in flight.
- Digits change only in STORE; there is no glitch or partial update between STOREs.

Test Plan:
1. Reset held 3 cycles, then released, no writes -> out_port0..2=0; dt0..dt5=1111111 until first STOREs; after refresh at cycle 30 all digits=1000000 ("00").
2. wen=1, addr=0x80, datain=42; addr=0x84, datain=7; addr=0x88, datain=99 -> ports=42,7,99 next cycle; after the next full refresh dt0..dt5 show 4,2,0,7,9,9.
3. Write port0=255 and port1=0x12345678 (low byte 0x78=120) -> dt0/dt1 "55", dt2/dt3 "20"; out_port1 reads back 0x12345678.
4. wen=1 with addr=0x8C, then wen=0 with addr=0x80 -> no port changes; addr=0x83 (addr[1:0]=3) with wen=1 writes port0.
5. Write port0 in the same cycle its LOAD occurs -> the old value is displayed for that round; the new value appears by the following refresh (<=40 cycles).
6. Assert resetn=0 mid-SHIFT for port1 -> next cycle ports=0, digits blank, refresh=0; conversion restarts at port0 with the first refresh 30 cycles after release.
